i2c_master_byte_ctrl: RTL
=========================

# i2c_master_byte_ctrl

Byte-level I2C master controller sitting directly upstream of the I2C master bit PHY. It accepts one byte transaction per request (optional START, 8 data bits, ACK bit, optional STOP) and sequences them into single-bit PHY commands. Write bits go out MSB first; read bits are assembled MSB first. It reports received data, the ACK/NACK status and arbitration loss to the host-side register/stream logic.

## Interface
- TIMEOUT_TICKS, 65535: clk_i cycles allowed per PHY command before abort; used only with the timeout feature.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_start_i  in  1  issue START before the byte
- req_stop_i  in  1  issue STOP after the ACK bit
- req_read_i  in  1  1 = read byte and drive ACK; 0 = write byte and sample ACK
- req_nack_i  in  1  read only: send NACK (1) instead of ACK (0)
- req_data_i  in  8  byte to write
- rsp_valid_o  out  1  one-cycle pulse; transaction finished
- rsp_data_o  out  8  byte read; holds its value until the next read response
- rsp_nack_o  out  1  write: slave NACKed; read: the value that was sent
- rsp_arb_lost_o  out  1  transaction aborted on arbitration loss
- rsp_timeout_o  out  1  transaction aborted on timeout; constant 0 when the feature is compiled out
- phy_cmd_o  out  3  PHY command in i2c_master_pkg encoding (START/STOP/READ/WRITE); any other value is NOP, driven as 0
- phy_data_o  out  1  bit to write
- phy_data_i  in  1  bit read, valid at phy_cmd_done_i
- phy_cmd_done_i  in  1  PHY finished current command
- phy_arb_lost_i  in  1  PHY arbitration lost pulse
- phy_bus_busy_i  in  1  bus held between START and STOP

## Operation
- States: IDLE, WAIT_BUS, START, BIT, ACK, STOP.
- IDLE: req_ready_o=1. On valid&&ready, latch all req fields into the shift register and flags. Next state:
  - WAIT_BUS if req_start_i, phy_bus_busy_i=1 and the own flag is 0;
  - START if req_start_i and not blocked;
  - BIT otherwise.
- WAIT_BUS: go to START once phy_bus_busy_i=0.
- START: phy_cmd_o=START. On done: set the own flag, load bit counter to 7, go to BIT.
- BIT:
  - write: phy_cmd_o=WRITE, phy_data_o=shift[7];
  - read: phy_cmd_o=READ, and phy_data_i shifts into the LSB on done.
  - On done: counter 0 → ACK; otherwise decrement, and shift left for writes.
- ACK:
  - write: phy_cmd_o=READ; capture phy_data_i into the NACK flag on done;
  - read: phy_cmd_o=WRITE, phy_data_o=latched nack.
  - On done: STOP if the stop flag is set, else finish.
- STOP: phy_cmd_o=STOP. On done: clear the own flag and finish.
- Finish: next cycle rsp_valid_o=1 with the result fields; return to IDLE.
- phy_cmd_o is registered. In the cycle phy_cmd_done_i=1 it is loaded with the next command, or NOP if the next state is IDLE.
- phy_arb_lost_i=1 in any non-IDLE state:
  - phy_cmd_o goes to NOP;
  - the own flag is cleared;
  - rsp_valid_o and rsp_arb_lost_o are pulsed next cycle;
  - the state returns to IDLE.
  - Arbitration loss has priority over a simultaneous phy_cmd_done_i.
- phy_arb_lost_i in IDLE is ignored.
- Without req_start_i, the request proceeds regardless of phy_bus_busy_i.

## Timing
- Reset values:
  - req_ready_o=1;
  - rsp_valid_o, rsp_nack_o, rsp_arb_lost_o, rsp_timeout_o = 0;
  - rsp_data_o=0x00, phy_cmd_o=NOP, phy_data_o=1;
  - state IDLE, own flag 0.
- Reset mid-transaction: outputs return to reset values immediately; no response is issued.
- Accept cycle N: phy_cmd_o is valid at N+1.
- Final phy_cmd_done_i at cycle M: rsp_valid_o=1 at M+1. req_ready_o=1 from M+1, so the next request can be accepted at M+1.
- Command count per transaction: 1 (START, optional) + 8 (data) + 1 (ACK) + 1 (STOP, optional).
- phy_data_o is stable for the whole duration of a WRITE command.

## Configuration
- I2C_BYTE_CTRL_TIMEOUT_EN defined:
  - a 32-bit counter clears on every phy_cmd_done_i and on each new command;
  - when it reaches TIMEOUT_TICKS in a non-IDLE state: phy_cmd_o=NOP, own flag cleared, rsp_valid_o and rsp_timeout_o pulsed, return to IDLE.
- I2C_BYTE_CTRL_TIMEOUT_EN undefined: no counter; rsp_timeout_o tied to 0; the controller waits for phy_cmd_done_i indefinitely.

## Test plan
- Write 0xA5 with start=1, stop=1, slave ACK → PHY command sequence START, 8 WRITE with bits 1,0,1,0,0,1,0,1, READ, STOP; response rsp_nack_o=0.
- Read, PHY returns bits 0x3C, req_nack_i=1, stop=0 → rsp_data_o=0x3C; final command is WRITE with data 1; no STOP issued.
- Write 0xFF, slave NACKs (phy_data_i=1 in the ACK bit) → rsp_nack_o=1.
- phy_arb_lost_i during bit 3 → phy_cmd_o=NOP next cycle; rsp_arb_lost_o=1; req_ready_o=1.
- start=1 with phy_bus_busy_i=1 and own flag 0 → phy_cmd_o stays NOP until busy drops, then START is issued.
- With I2C_BYTE_CTRL_TIMEOUT_EN and TIMEOUT_TICKS=100, PHY never sends done → at cycle 100 after the command is issued: rsp_timeout_o=1 and state IDLE.

Source files
------------

// File: rtl/i2c_master_byte_ctrl_if.sv
// PHY command encoding plus the request/response/PHY bundle for the byte controller.
// master = controller side, slave = host/PHY side.
package i2c_master_pkg;
  localparam logic [2:0] PHY_NOP   = 3'd0;
  localparam logic [2:0] PHY_START = 3'd1;
  localparam logic [2:0] PHY_STOP  = 3'd2;
  localparam logic [2:0] PHY_WRITE = 3'd3;
  localparam logic [2:0] PHY_READ  = 3'd4;
endpackage

interface i2c_master_byte_ctrl_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_start_i;
  logic       req_stop_i;
  logic       req_read_i;
  logic       req_nack_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;
  logic       rsp_nack_o;
  logic       rsp_arb_lost_o;
  logic       rsp_timeout_o;
  logic [2:0] phy_cmd_o;
  logic       phy_data_o;
  logic       phy_data_i;
  logic       phy_cmd_done_i;
  logic       phy_arb_lost_i;
  logic       phy_bus_busy_i;

  modport master (
    input  req_valid_i, req_start_i, req_stop_i, req_read_i, req_nack_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_nack_o, rsp_arb_lost_o, rsp_timeout_o,
    output phy_cmd_o, phy_data_o,
    input  phy_data_i, phy_cmd_done_i, phy_arb_lost_i, phy_bus_busy_i
  );

  modport slave (
    output req_valid_i, req_start_i, req_stop_i, req_read_i, req_nack_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_nack_o, rsp_arb_lost_o, rsp_timeout_o,
    input  phy_cmd_o, phy_data_o,
    output phy_data_i, phy_cmd_done_i, phy_arb_lost_i, phy_bus_busy_i
  );
endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: sequences START / 8 data bits / ACK / STOP into single-bit PHY commands.
// Optional per-command watchdog enabled by defining I2C_BYTE_CTRL_TIMEOUT_EN.
module i2c_master_byte_ctrl
  import i2c_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 65535
) (
  input logic clk_i,
  input logic rst_i,
  i2c_master_byte_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_BUS, S_START, S_BIT, S_ACK, S_STOP} state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       own_q, own_d;
  logic       read_q, read_d;
  logic       stop_q, stop_d;
  logic       nack_q, nack_d;
  logic [2:0] phy_cmd_q, phy_cmd_d;
  logic       phy_data_q, phy_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic       rsp_arb_q, rsp_arb_d;
  logic       rsp_tmo_q, rsp_tmo_d;
  logic       load, finish, arb_abort, tmo_hit;

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
  logic [31:0] tmo_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                  tmo_q <= '0;
    else if (state_q == S_IDLE || bus.phy_cmd_done_i || load)   tmo_q <= '0;
    else                                                        tmo_q <= tmo_q + 32'd1;
  end
  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TIMEOUT_TICKS);
`else
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = ^TIMEOUT_TICKS;
  assign tmo_hit = 1'b0;
`endif

  assign arb_abort = (state_q != S_IDLE) && bus.phy_arb_lost_i;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    own_d       = own_q;
    read_d      = read_q;
    stop_d      = stop_q;
    nack_d      = nack_q;
    phy_cmd_d   = phy_cmd_q;
    phy_data_d  = phy_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    rsp_arb_d   = 1'b0;
    rsp_tmo_d   = 1'b0;
    load        = 1'b0;
    finish      = 1'b0;

    case (state_q)
      S_IDLE: if (bus.req_valid_i) begin
        read_d  = bus.req_read_i;
        stop_d  = bus.req_stop_i;
        nack_d  = bus.req_read_i & bus.req_nack_i;
        shift_d = bus.req_data_i;
        cnt_d   = 3'd7;
        load    = 1'b1;
        if (bus.req_start_i)
          state_d = (bus.phy_bus_busy_i && !own_q) ? S_WAIT_BUS : S_START;
        else
          state_d = S_BIT;
      end
      S_WAIT_BUS: if (!bus.phy_bus_busy_i) begin
        state_d = S_START;
        load    = 1'b1;
      end
      S_START: if (bus.phy_cmd_done_i) begin
        own_d   = 1'b1;
        cnt_d   = 3'd7;
        state_d = S_BIT;
        load    = 1'b1;
      end
      S_BIT: if (bus.phy_cmd_done_i) begin
        shift_d = read_q ? {shift_q[6:0], bus.phy_data_i} : {shift_q[6:0], 1'b0};
        load    = 1'b1;
        if (cnt_q == 3'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ACK: if (bus.phy_cmd_done_i) begin
        if (!read_q) nack_d = bus.phy_data_i;
        if (stop_q) begin
          state_d = S_STOP;
          load    = 1'b1;
        end else begin
          finish = 1'b1;
        end
      end
      S_STOP: if (bus.phy_cmd_done_i) begin
        own_d  = 1'b0;
        finish = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Aborts win over any completion seen in the same cycle.
    if (arb_abort || tmo_hit) begin
      state_d     = S_IDLE;
      own_d       = 1'b0;
      phy_cmd_d   = PHY_NOP;
      phy_data_d  = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_nack_d  = 1'b0;
      rsp_arb_d   = arb_abort;
      rsp_tmo_d   = tmo_hit;
    end else if (finish) begin
      state_d     = S_IDLE;
      phy_cmd_d   = PHY_NOP;
      phy_data_d  = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_nack_d  = nack_d;
      if (read_q) rsp_data_d = shift_d;
    end else if (load) begin
      phy_data_d = 1'b1;
      case (state_d)
        S_START: phy_cmd_d = PHY_START;
        S_BIT: begin
          phy_cmd_d = read_d ? PHY_READ : PHY_WRITE;
          if (!read_d) phy_data_d = shift_d[7];
        end
        S_ACK: begin
          phy_cmd_d = read_d ? PHY_WRITE : PHY_READ;
          if (read_d) phy_data_d = nack_d;
        end
        S_STOP:  phy_cmd_d = PHY_STOP;
        default: phy_cmd_d = PHY_NOP;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      own_q       <= 1'b0;
      read_q      <= 1'b0;
      stop_q      <= 1'b0;
      nack_q      <= 1'b0;
      phy_cmd_q   <= PHY_NOP;
      phy_data_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
      rsp_arb_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      read_q      <= read_d;
      stop_q      <= stop_d;
      nack_q      <= nack_d;
      phy_cmd_q   <= phy_cmd_d;
      phy_data_q  <= phy_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_arb_q   <= rsp_arb_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign bus.req_ready_o    = (state_q == S_IDLE);
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign bus.rsp_nack_o     = rsp_nack_q;
  assign bus.rsp_arb_lost_o = rsp_arb_q;
  assign bus.rsp_timeout_o  = rsp_tmo_q;
  assign bus.phy_cmd_o      = phy_cmd_q;
  assign bus.phy_data_o     = phy_data_q;

endmodule
